serial_sub_ctrl: RTL and testbench

Bit-serial subtraction controller that sequences the 1-bit full-subtractor cell `ful_sub` (ports `a`, `b`, `c`, `dif`, `bor`) over a WIDTH-bit operand pair, one bit per clock, LSB first. It computes a − b − bin. It sits between a requester with a start/busy/done handshake and a single shared `ful_sub` instance. This trades WIDTH cycles of latency for one subtractor cell.

---
 rtl/serial_sub_ctrl.sv | 113 +++++++++++
 tb/tb_serial_sub_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one shared full-subtractor cell walks a WIDTH-bit
// operand pair LSB first and returns (a - b - bin) plus the final borrow.
`timescale 1ns/1ps

module ful_sub (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic dif,
  output logic bor
);
  assign dif = a ^ b ^ c;
  assign bor = (~a & (b | c)) | (b & c);
endmodule

module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dif,
  output logic             bor
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             cell_dif;
  logic             cell_bor;
  logic             last_bit;

  ful_sub u_cell (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .c   (borrow),
    .dif (cell_dif),
    .bor (cell_bor)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  // The completed word includes the bit being produced on this edge.
  assign res_next = {cell_dif, res_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)    state_next = RUN;
      RUN:     if (last_bit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      dif    <= '0;
      bor    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= bin;
            cnt    <= '0;
          end
        end
        RUN: begin
          res_sr <= res_next;
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          borrow <= cell_bor;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            dif  <= res_next;
            bor  <= cell_bor;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed and table-driven bench for serial_sub_ctrl, with a WIDTH=4
// instance swept over every operand combination against an arithmetic model.
`timescale 1ns/1ps

module tb_serial_sub_ctrl;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] exp_dif;
    logic       exp_bor;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] dif;
  logic       bor;

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       bin4;
  logic       busy4;
  logic       done4;
  logic [3:0] dif4;
  logic       bor4;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_dif;
  logic       last_bor;

  vec_t vecs[9];
  vec_t chain[4];

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .dif   (dif),
    .bor   (bor)
  );

  serial_sub_ctrl #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .bin   (bin4),
    .busy  (busy4),
    .done  (done4),
    .dif   (dif4),
    .bor   (bor4)
  );

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Steps negedge by negedge until done, also noting busy cycles and whether
  // the registered outputs moved before the done edge.
  task automatic waitDone(output int lat, output int busy_cnt, output logic hold_bad);
    lat      = 0;
    busy_cnt = 0;
    hold_bad = 1'b0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) busy_cnt++;
      if (dif !== last_dif || bor !== last_bor) hold_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int   lat;
    int   busy_cnt;
    logic hold_bad;
    a     = v.a;
    b     = v.b;
    bin   = v.bin;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = ~v.a;
    b     = ~v.b;
    bin   = ~v.bin;
    waitDone(lat, busy_cnt, hold_bad);
    checkOutput({v.name, " done"}, 32'(done), 32'd1);
    checkOutput({v.name, " latency"}, 32'(lat), 32'd8);
    checkOutput({v.name, " busy cycles"}, 32'(busy_cnt), 32'd8);
    checkOutput({v.name, " busy at done"}, 32'(busy), 32'd0);
    checkOutput({v.name, " dif"}, 32'(dif), 32'(v.exp_dif));
    checkOutput({v.name, " bor"}, 32'(bor), 32'(v.exp_bor));
    checkOutput({v.name, " hold"}, 32'(hold_bad), 32'd0);
    last_dif = v.exp_dif;
    last_bor = v.exp_bor;
    @(negedge clk);
    checkOutput({v.name, " done pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int         lat;
    int         busy_cnt;
    int         done_cnt;
    int         idx;
    int         off;
    logic       hold_bad;
    logic [8:0] code;
    logic [4:0] exp4;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, "5A-3C"};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "00-01"};
    vecs[2] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, "80-7F-1"};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "FF-FF-1"};
    vecs[4] = '{8'h3C, 8'h5A, 1'b0, 8'hE2, 1'b1, "3C-5A"};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "00-00-1"};
    vecs[6] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, "FF-00"};
    vecs[7] = '{8'h01, 8'h00, 1'b1, 8'h00, 1'b0, "01-00-1"};
    vecs[8] = '{8'h09, 8'h04, 1'b0, 8'h05, 1'b0, "09-04"};

    chain[0] = '{8'h12, 8'h34, 1'b0, 8'hDE, 1'b1, "chain0"};
    chain[1] = '{8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, "chain1"};
    chain[2] = '{8'h77, 8'h77, 1'b0, 8'h00, 1'b0, "chain2"};
    chain[3] = '{8'h01, 8'h02, 1'b1, 8'hFE, 1'b1, "chain3"};

    rst_n  = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    bin    = 1'b0;
    start4 = 1'b0;
    a4     = '0;
    b4     = '0;
    bin4   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset dif", 32'(dif), 32'd0);
    checkOutput("reset bor", 32'(bor), 32'd0);
    last_dif = '0;
    last_bor = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] table vectors");
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    $display("[TB] start while busy is ignored");
    a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midrun busy", 32'(busy), 32'd1);
    start = 1'b1; a = 8'hFF; b = 8'h00; bin = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'h55; b = 8'hAA;
    @(negedge clk);
    a = 8'h33; b = 8'hCC;
    waitDone(lat, busy_cnt, hold_bad);
    checkOutput("midrun latency", 32'(lat + 5), 32'd8);
    checkOutput("midrun dif", 32'(dif), 32'h0F);
    checkOutput("midrun bor", 32'(bor), 32'd0);
    last_dif = 8'h0F;
    last_bor = 1'b0;
    done_cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    checkOutput("midrun extra done", 32'(done_cnt), 32'd0);

    $display("[TB] reset during run");
    a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    checkOutput("abort dif", 32'(dif), 32'd0);
    checkOutput("abort bor", 32'(bor), 32'd0);
    last_dif = '0;
    last_bor = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_cnt++;
    end
    checkOutput("abort no done", 32'(done_cnt), 32'd0);
    applyStimulus(vecs[8]);

    $display("[TB] back-to-back with start held");
    a = chain[0].a; b = chain[0].b; bin = chain[0].bin; start = 1'b1;
    @(negedge clk);
    a = chain[1].a; b = chain[1].b; bin = chain[1].bin;
    for (int k = 0; k < 4; k++) begin
      waitDone(lat, busy_cnt, hold_bad);
      checkOutput({chain[k].name, " latency"}, 32'(lat), 32'd8);
      checkOutput({chain[k].name, " dif"}, 32'(dif), 32'(chain[k].exp_dif));
      checkOutput({chain[k].name, " bor"}, 32'(bor), 32'(chain[k].exp_bor));
      checkOutput({chain[k].name, " hold"}, 32'(hold_bad), 32'd0);
      last_dif = chain[k].exp_dif;
      last_bor = chain[k].exp_bor;
      if (k < 3) begin
        @(negedge clk);
        checkOutput({chain[k].name, " reaccept busy"}, 32'(busy), 32'd1);
        checkOutput({chain[k].name, " reaccept done"}, 32'(done), 32'd0);
        if (k + 2 <= 3) begin
          a = chain[k+2].a; b = chain[k+2].b; bin = chain[k+2].bin;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("chain idle", 32'(busy), 32'd0);

    $display("[TB] WIDTH=4 sweep");
    off = int'($urandom_range(0, 511));
    for (int i = 0; i < 512; i++) begin
      idx  = (i * 37 + off) % 512;
      code = 9'(idx);
      a4   = code[3:0];
      b4   = code[7:4];
      bin4 = code[8];
      exp4 = {1'b0, code[3:0]} - {1'b0, code[7:4]} - {4'b0, code[8]};
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      a4 = ~a4;
      lat = 0;
      while (done4 !== 1'b1 && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      checkOutput($sformatf("w4 %0h-%0h-%0d", code[3:0], code[7:4], code[8]),
                  32'({bor4, dif4, 3'(lat)}), 32'({exp4, 3'd4}));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
